seg_scan_ctrl: RTL and testbench

Autonomous scan scheduler for the 7-segment/keypad decode datapath. It holds four 4-bit digit values and time-multiplexes them across the four screens. It walks the four keypad columns and emits one 8-bit command byte per scan slot in the decoder's command format {col[1:0], screen[1:0], digit[3:0]}. It samples the decoder's active-low key return line, debounces all 16 keys and queues press/release events for the host.

---
 rtl/seg_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------------------------
// seg_scan_ctrl
//
// Autonomous scan scheduler for the 7-segment / keypad decode datapath.
// - Holds four 4-bit digit values and time-multiplexes them across four screens.
// - Walks the four keypad columns and emits one command byte {col, screen, digit}
//   per scan slot.
// - Samples the decoder's active-low key return, debounces all 16 keys and queues
//   press/release events in a 4-deep first-word-fall-through FIFO.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   digit write strobe
//   wr_addr    in   [1:0] screen index written
//   wr_data    in   [3:0] digit value
//   cmd_byte   out  [7:0] {col[1:0], screen[1:0], digit[3:0]}, held for the slot
//   cmd_valid  out  one-cycle pulse when cmd_byte is reloaded
//   key_n      in   decoder key return, 0 = addressed key pressed (asynchronous)
//   key_valid  out  event FIFO not empty
//   key_ready  in   host accepts the head event
//   key_code   out  [3:0] {screen, col} of the head event
//   key_press  out  head event type, 1 = press, 0 = release
//   ovf        out  sticky flag, an event was dropped on a full FIFO
// ---------------------------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int unsigned DWELL = 16,
    parameter int unsigned DEB   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [7:0] cmd_byte,
    output logic       cmd_valid,
    input  logic       key_n,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [3:0] key_code,
    output logic       key_press,
    output logic       ovf
);

    localparam int unsigned DwellW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned FifoDepth = 4;

    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL - 1);
    // Counter value at which the next differing sample completes the debounce run.
    localparam logic [2:0]        DebLast   = 3'(DEB - 1);
    localparam logic [2:0]        FifoFull  = 3'(FifoDepth);

    // -----------------------------------------------------------------------------------------
    // Slot sequencing
    // -----------------------------------------------------------------------------------------
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [3:0]        slot_q, slot_d;
    logic [1:0]        screen;
    logic [1:0]        col;
    logic              slot_first;
    logic              slot_last;

    assign screen     = slot_q[1:0];
    assign col        = slot_q[3:2];
    assign slot_first = (dwell_q == '0);
    assign slot_last  = (dwell_q == DwellLast);

    always_comb begin
        dwell_d = dwell_q + DwellW'(1);
        slot_d  = slot_q;
        if (slot_last) begin
            dwell_d = '0;
            slot_d  = slot_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            slot_q  <= '0;
        end else begin
            dwell_q <= dwell_d;
            slot_q  <= slot_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Digit register file
    // -----------------------------------------------------------------------------------------
    logic [3:0][3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (wr_en) begin
            digit_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Command byte
    // -----------------------------------------------------------------------------------------
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic       cmd_valid_q, cmd_valid_d;

    // The load reads digit_q, so a write landing on the same edge shows up a frame later.
    always_comb begin
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = slot_first;
        if (slot_first) begin
            cmd_byte_d = {col, screen, digit_q[screen]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_byte_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
        end else begin
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign cmd_byte  = cmd_byte_q;
    assign cmd_valid = cmd_valid_q;

    // -----------------------------------------------------------------------------------------
    // Key return synchroniser
    // -----------------------------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Per-key debounce
    // -----------------------------------------------------------------------------------------
    logic [15:0]      stable_q, stable_d;
    logic [15:0][2:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]       key_idx;
    logic             sample_pressed;
    logic             evt_push;
    logic [4:0]       evt_data;

    assign key_idx        = {screen, col};
    assign sample_pressed = ~sync2_q;

    // Only the key addressed by the current slot is touched, once per frame on the slot's
    // last cycle, so the synchronised return has settled for the whole slot.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        evt_push  = 1'b0;
        evt_data  = {key_idx, ~stable_q[key_idx]};
        if (slot_last) begin
            if (sample_pressed == stable_q[key_idx]) begin
                deb_cnt_d[key_idx] = '0;
            end else if (deb_cnt_q[key_idx] >= DebLast) begin
                stable_d[key_idx]  = sample_pressed;
                deb_cnt_d[key_idx] = '0;
                evt_push           = 1'b1;
            end else begin
                deb_cnt_d[key_idx] = deb_cnt_q[key_idx] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q  <= '0;
            deb_cnt_q <= '0;
        end else begin
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // -----------------------------------------------------------------------------------------
    logic [FifoDepth-1:0][4:0] fifo_q, fifo_d;
    logic [1:0]                rd_ptr_q, rd_ptr_d;
    logic [1:0]                wr_ptr_q, wr_ptr_d;
    logic [2:0]                count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic                      fifo_full;
    logic                      fifo_nempty;
    logic                      do_pop;
    logic                      do_push;

    assign fifo_full   = (count_q == FifoFull);
    assign fifo_nempty = (count_q != 3'd0);
    assign do_pop      = fifo_nempty & key_ready;
    // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts it.
    assign do_push     = evt_push & (~fifo_full | do_pop);

    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (do_push) begin
            fifo_d[wr_ptr_q] = evt_data;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        if (do_push && !do_pop) begin
            count_d = count_q + 3'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 3'd1;
        end

        if (evt_push && !do_push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Head fields read as zero while empty so stale entries never leak out.
    assign key_valid = fifo_nempty;
    assign key_code  = fifo_nempty ? fifo_q[rd_ptr_q][4:1] : 4'h0;
    assign key_press = fifo_nempty ? fifo_q[rd_ptr_q][0] : 1'b0;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       key_n;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] key_code;
    logic       key_press;
    logic       ovf;

    int unsigned n_pass;
    int unsigned n_total;
    int unsigned cyc;
    logic [15:0] key_mask;

    logic [7:0] exp_scan [16] = '{
        8'h01, 8'h12, 8'h23, 8'h34, 8'h41, 8'h52, 8'h63, 8'h74,
        8'h81, 8'h92, 8'hA3, 8'hB4, 8'hC1, 8'hD2, 8'hE3, 8'hF4
    };

    seg_scan_ctrl #(
        .DWELL(4),
        .DEB  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cmd_byte (cmd_byte),
        .cmd_valid(cmd_valid),
        .key_n    (key_n),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_code (key_code),
        .key_press(key_press),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    // Keypad model: pulls the return low while the scan addresses a held key.
    task automatic drive_key();
        logic [3:0] s;
        logic [3:0] k;
        s = 4'((cyc / 4) % 16);
        k = {s[1:0], s[3:2]};
        key_n = ~key_mask[k];
    endtask

    task automatic set_mask(input logic [15:0] m);
        key_mask = m;
        drive_key();
    endtask

    // Cycle k means 1 time unit after the k-th rising edge since reset release.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_key();
    endtask

    task automatic goto(input int unsigned target);
        while (cyc < target) step();
    endtask

    task automatic chk_head(input string tag, input logic [3:0] code, input logic press);
        chk({tag, "_valid"}, {7'd0, key_valid}, 8'd1);
        chk({tag, "_code"}, {4'd0, key_code}, {4'd0, code});
        chk({tag, "_press"}, {7'd0, key_press}, {7'd0, press});
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        cyc       = 0;
        key_mask  = '0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 2'd0;
        wr_data   = 4'd0;
        key_n     = 1'b1;
        key_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_cmd_byte", cmd_byte, 8'h00);
        chk("rst_cmd_valid", {7'd0, cmd_valid}, 8'd0);
        chk("rst_key_valid", {7'd0, key_valid}, 8'd0);
        chk("rst_key_code", {4'd0, key_code}, 8'd0);
        chk("rst_key_press", {7'd0, key_press}, 8'd0);
        chk("rst_ovf", {7'd0, ovf}, 8'd0);

        // Release reset; write digits 1..4 on the first four edges
        rst_n   = 1'b1;
        cyc     = 0;
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 4'd1;
        step();
        chk("first_valid", {7'd0, cmd_valid}, 8'd1);
        chk("first_byte", cmd_byte, 8'h00);
        wr_addr = 2'd1;
        wr_data = 4'd2;
        step();
        chk("first_valid_pulse", {7'd0, cmd_valid}, 8'd0);
        wr_addr = 2'd2;
        wr_data = 4'd3;
        step();
        wr_addr = 2'd3;
        wr_data = 4'd4;
        step();
        wr_en = 1'b0;

        // Test 1: scan sequence
        for (int s = 1; s < 16; s++) begin
            goto(4 * s + 1);
            chk("scan_byte", cmd_byte, exp_scan[s]);
            chk("scan_valid", {7'd0, cmd_valid}, 8'd1);
            goto(4 * s + 2);
            chk("scan_hold_byte", cmd_byte, exp_scan[s]);
            chk("scan_hold_valid", {7'd0, cmd_valid}, 8'd0);
        end
        goto(65);
        chk("wrap_byte", cmd_byte, 8'h01);
        chk("wrap_valid", {7'd0, cmd_valid}, 8'd1);

        // Test 2: write on the slot-0 load edge
        goto(128);
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 4'h9;
        step();
        wr_en = 1'b0;
        chk("race_old_byte", cmd_byte, 8'h01);
        goto(193);
        chk("race_new_byte", cmd_byte, 8'h09);

        // Test 3: single-frame glitch on key 9 -> no event
        goto(256);
        set_mask(16'h0200);
        goto(320);
        set_mask(16'h0000);
        goto(285);
        chk("glitch_none_a", {7'd0, key_valid}, 8'd0);
        goto(448);
        chk("glitch_none_b", {7'd0, key_valid}, 8'd0);

        // Test 3: press held two frames
        set_mask(16'h0200);
        goto(539);
        chk("press_early", {7'd0, key_valid}, 8'd0);
        step();
        chk_head("press", 4'h9, 1'b1);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        chk("press_popped", {7'd0, key_valid}, 8'd0);

        // Test 4: release
        goto(576);
        set_mask(16'h0000);
        goto(667);
        chk("release_early", {7'd0, key_valid}, 8'd0);
        step();
        chk_head("release", 4'h9, 1'b0);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        chk("release_popped", {7'd0, key_valid}, 8'd0);

        // Test 5: five presses with no host -> fifth dropped
        goto(704);
        set_mask(16'h001F);
        goto(819);
        chk("ovf_before", {7'd0, ovf}, 8'd0);
        chk("ovf_valid_before", {7'd0, key_valid}, 8'd1);
        step();
        chk("ovf_set", {7'd0, ovf}, 8'd1);
        chk_head("ovf_head", 4'h0, 1'b1);

        // Push on full FIFO together with a pop: release of key 0 is kept
        goto(832);
        set_mask(16'h001E);
        goto(899);
        chk_head("full_pre", 4'h0, 1'b1);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        chk_head("full_pushpop", 4'h4, 1'b1);
        key_ready = 1'b1;
        step();
        chk_head("drain1", 4'h1, 1'b1);
        step();
        chk_head("drain2", 4'h2, 1'b1);
        step();
        chk_head("drain3", 4'h0, 1'b0);
        step();
        key_ready = 1'b0;
        chk("drain_empty", {7'd0, key_valid}, 8'd0);
        chk("ovf_sticky", {7'd0, ovf}, 8'd1);

        // Test 6: mid-slot reset with events queued
        goto(960);
        set_mask(16'h0000);
        goto(1078);
        chk_head("queued", 4'h4, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_key_valid", {7'd0, key_valid}, 8'd0);
        chk("mid_rst_key_code", {4'd0, key_code}, 8'd0);
        chk("mid_rst_ovf", {7'd0, ovf}, 8'd0);
        chk("mid_rst_cmd_byte", cmd_byte, 8'h00);
        chk("mid_rst_cmd_valid", {7'd0, cmd_valid}, 8'd0);
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
        drive_key();
        step();
        chk("restart_valid", {7'd0, cmd_valid}, 8'd1);
        chk("restart_byte", cmd_byte, 8'h00);
        goto(5);
        chk("restart_slot1", cmd_byte, 8'h10);
        goto(140);
        chk("restart_no_evt", {7'd0, key_valid}, 8'd0);
        chk("restart_ovf", {7'd0, ovf}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
